// File: rtl/load_store_unit.sv
// ARMv4 load/store unit: LDR/STR/LDRB/STRB over a word-addressed memory.
// Byte stores are read-modify-write; loads rotate/extract per byte offset.
module load_store_unit #(
    parameter int bus     = 32,
    parameter int memsize = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic           req_byte,
    input  logic [bus-1:0] req_addr,
    input  logic [bus-1:0] req_wdata,
    output logic           resp_valid,
    output logic [bus-1:0] resp_rdata,
    output logic           resp_err,
    output logic           MRE,
    output logic           MWE,
    output logic [bus-1:0] mem_readdir,
    output logic [bus-1:0] mem_writedir,
    output logic [bus-1:0] mem_datain,
    input  logic [bus-1:0] mem_dataout
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR,
        DONE
    } state_t;

    localparam logic [bus-1:0] MEMSIZE = bus'(memsize);

    state_t         state;
    state_t         state_n;
    logic [bus-1:0] idx_q;
    logic [bus-1:0] wdata_q;
    logic [1:0]     off_q;
    logic           write_q;
    logic           byte_q;

    logic [bus-1:0] req_idx;
    logic           accept;
    logic           oor;
    logic [bus-1:0] rot;
    logic [7:0]     byte_sel;
    logic [bus-1:0] load_res;
    logic [bus-1:0] merged;

    assign req_idx = {2'b00, req_addr[bus-1:2]};
    assign accept  = req_valid & req_ready;
    assign oor     = req_idx >= MEMSIZE;

    always_comb begin
        rot = mem_dataout;
        unique case (off_q)
            2'd1:    rot = {mem_dataout[7:0],  mem_dataout[bus-1:8]};
            2'd2:    rot = {mem_dataout[15:0], mem_dataout[bus-1:16]};
            2'd3:    rot = {mem_dataout[23:0], mem_dataout[bus-1:24]};
            default: rot = mem_dataout;
        endcase
    end

    assign byte_sel = mem_dataout[{off_q, 3'b000} +: 8];
    assign load_res = byte_q ? {{(bus-8){1'b0}}, byte_sel} : rot;

    // Byte store: the fetched word with one lane replaced.
    always_comb begin
        merged = mem_dataout;
        merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (oor)
                        state_n = DONE;
                    else if (req_write && !req_byte)
                        state_n = WR;
                    else
                        state_n = RD_ISSUE;
                end
            end
            RD_ISSUE: state_n = RD_WAIT;
            RD_WAIT:  state_n = write_q ? WR : DONE;
            WR:       state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx_q      <= '0;
            wdata_q    <= '0;
            off_q      <= '0;
            write_q    <= 1'b0;
            byte_q     <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                idx_q    <= req_idx;
                off_q    <= req_addr[1:0];
                wdata_q  <= req_wdata;
                write_q  <= req_write;
                byte_q   <= req_byte;
                resp_err <= oor;
                if (oor)
                    resp_rdata <= '0;
            end
            if (state == RD_WAIT) begin
                if (write_q)
                    wdata_q <= merged;
                else
                    resp_rdata <= load_res;
            end
        end
    end

    assign req_ready    = (state == IDLE);
    assign resp_valid   = (state == DONE);
    assign MRE          = (state == RD_ISSUE);
    assign MWE          = (state == WR);
    assign mem_readdir  = MRE ? idx_q : '0;
    assign mem_writedir = MWE ? idx_q : '0;
    assign mem_datain   = MWE ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a word memory model.
// Memory reads register at posedge on MRE; writes commit at negedge on MWE.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MRE;
    logic        MWE;
    logic [31:0] mem_readdir;
    logic [31:0] mem_writedir;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout = '0;

    logic [31:0] mem [0:4095];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.bus(32), .memsize(4096)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_byte(req_byte),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .MRE(MRE),
        .MWE(MWE),
        .mem_readdir(mem_readdir),
        .mem_writedir(mem_writedir),
        .mem_datain(mem_datain),
        .mem_dataout(mem_dataout)
    );

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[5] = 32'h11223344;
        forever begin
            @(negedge clk);
            if (MWE) mem[mem_writedir[11:0]] = mem_datain;
        end
    end

    always @(posedge clk)
        if (MRE) mem_dataout <= mem[mem_readdir[11:0]];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic w, input logic b,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_mre,
                          input int exp_mwe, input logic [31:0] exp_dir);
        int n;
        int mre_n;
        int mwe_n;
        bit seen;
        logic [31:0] dir;
        chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        req_write = w;
        req_byte  = b;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1; seen = 0; mre_n = 0; mwe_n = 0; dir = '0;
        while (!seen && n <= 10) begin
            if (MRE) begin mre_n++; dir = mem_readdir; end
            if (MWE) begin mwe_n++; dir = mem_writedir; end
            if (resp_valid) seen = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " rdata"}, resp_rdata, exp_rd);
        chk({tag, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
        chk({tag, " mre"}, 32'(mre_n), 32'(exp_mre));
        chk({tag, " mwe"}, 32'(mwe_n), 32'(exp_mwe));
        if (exp_mre + exp_mwe > 0)
            chk({tag, " dir"}, dir, exp_dir);
        @(posedge clk); #1;
        chk({tag, " pulse"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, " ready after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int rv;
        int mr;
        int mw;
        #1;
        chk("rst ready", {31'd0, req_ready}, 32'd1);
        chk("rst valid", {31'd0, resp_valid}, 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst err", {31'd0, resp_err}, 32'd0);
        chk("rst mre", {31'd0, MRE}, 32'd0);
        chk("rst mwe", {31'd0, MWE}, 32'd0);
        chk("rst datain", mem_datain, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_req("ldr14", 0, 0, 32'h14, 0, 3, 32'h11223344, 0, 1, 0, 5);
        do_req("ldr15", 0, 0, 32'h15, 0, 3, 32'h44112233, 0, 1, 0, 5);
        do_req("ldr17", 0, 0, 32'h17, 0, 3, 32'h22334411, 0, 1, 0, 5);
        do_req("ldrb16", 0, 1, 32'h16, 0, 3, 32'h00000022, 0, 1, 0, 5);
        do_req("ldrb14", 0, 1, 32'h14, 0, 3, 32'h00000044, 0, 1, 0, 5);
        do_req("strb17", 1, 1, 32'h17, 32'hFFFFFFAB, 4, 32'h00000044,
               0, 1, 1, 5);
        chk("strb17 mem", mem[5], 32'hAB223344);
        do_req("ldr14b", 0, 0, 32'h14, 0, 3, 32'hAB223344, 0, 1, 0, 5);
        do_req("str22", 1, 0, 32'h22, 32'hDEADBEEF, 2, 32'hAB223344,
               0, 0, 1, 8);
        chk("str22 mem", mem[8], 32'hDEADBEEF);
        chk("str22 neighbour", mem[5], 32'hAB223344);
        do_req("ldr oor", 0, 0, 32'h4000, 0, 1, 32'h0, 1, 0, 0, 0);
        do_req("ldrb13", 0, 1, 32'h13, 0, 3, 32'h0, 0, 1, 0, 4);

        req_write = 1'b1; req_byte = 1'b1;
        req_addr = 32'h14; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort ready", {31'd0, req_ready}, 32'd1);
        chk("abort valid", {31'd0, resp_valid}, 32'd0);
        chk("abort rdata", resp_rdata, 32'd0);
        chk("abort mre", {31'd0, MRE}, 32'd0);
        chk("abort mwe", {31'd0, MWE}, 32'd0);
        chk("abort readdir", mem_readdir, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rv = 0; mw = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid) rv++;
            if (MWE) mw++;
        end
        chk("abort no resp", 32'(rv), 32'd0);
        chk("abort no write", 32'(mw), 32'd0);
        chk("abort mem", mem[5], 32'hAB223344);
        chk("abort ready after", {31'd0, req_ready}, 32'd1);

        req_write = 1'b0; req_byte = 1'b0;
        req_addr = 32'h14; req_wdata = 32'h0;
        req_valid = 1'b1;
        rv = 0; mr = 0;
        repeat (9) begin
            @(posedge clk); #1;
            if (resp_valid) rv++;
            if (MRE) mr++;
        end
        req_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid) rv++;
            if (MRE) mr++;
        end
        chk("held resp count", 32'(rv), 32'd3);
        chk("held mre count", 32'(mr), 32'd3);
        chk("held rdata", resp_rdata, 32'hAB223344);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
